// File: rtl/mem_loader.sv
// mem_loader: boot-time loader streaming words into memory, then passing the port to the datapath.
// Optional feature: define MEM_LOADER_CHECKSUM_EN so the last word is a checksum that is verified, not stored.
module mem_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_mrw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);
    typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;
    localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    state_t            state, nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              accept, store, last_ok;
    assign in_ready = state == LOAD;
    assign accept   = in_valid & in_ready;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    assign store   = accept & ~in_last;
    assign last_ok = sum_q == in_data;
    // running sum of stored words, compared against the trailing checksum word
    always_ff @(posedge clk) begin
        if (reset) sum_q <= '0;
        else if (store) sum_q <= sum_q + in_data;
    end
`else
    assign store   = accept;
    assign last_ok = 1'b1;
`endif
    // memory port mux and next-state selection; no wrap past the top of memory
    always_comb begin
        mem_addr  = state == DONE ? cpu_addr : addr_q;
        mem_wdata = state == DONE ? cpu_wdata : in_data;
        mem_we    = state == DONE ? cpu_mrw : store;
        nxt       = state;
        if (accept) nxt = in_last ? (last_ok ? DONE : ERR) : (addr_q == TOP ? ERR : LOAD);
    end
    // loader FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            addr_q     <= BASE;
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state    <= nxt;
            done     <= nxt == DONE;
            err      <= nxt == ERR;
            cpu_hold <= nxt != DONE;
            if (store) begin
                addr_q     <= addr_q + 1'b1;
                word_count <= word_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: two loaders (base 0 and base 4094) driven in parallel, checked against a transaction-level model.
module tb_mem_loader;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic clk = 0, reset = 1, in_valid = 0, in_last = 0, cpu_mrw = 0;
    logic [15:0] in_data = 0, cpu_addr = 0, cpu_wdata = 0;
    logic [1:0] rdy, we, hold, dn, er;
    logic [15:0] maddr[2], mwd[2], cnt[2];
    logic [15:0] mem[2][4096];
    int ms[2], ma[2], mc[2];
    logic [15:0] msum[2];
    logic [15:0] mm[2][4096];
    int base[2] = '{0, 4094};
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_loader #(.BASE_ADDR(0)) u0 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .in_last(in_last), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mrw(cpu_mrw),
        .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_we(we[0]), .cpu_hold(hold[0]), .done(dn[0]),
        .err(er[0]), .word_count(cnt[0]));
    mem_loader #(.BASE_ADDR(4094)) u1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .in_last(in_last), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_mrw(cpu_mrw),
        .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_we(we[1]), .cpu_hold(hold[1]), .done(dn[1]),
        .err(er[1]), .word_count(cnt[1]));

    always @(posedge clk) begin
        if (we[0] === 1'b1) mem[0][maddr[0][11:0]] <= mwd[0];
        if (we[1] === 1'b1) mem[1][maddr[1][11:0]] <= mwd[1];
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; ma[i] = base[i]; mc[i] = 0; msum[i] = 0;
        end
    endtask

    task automatic chk_status(string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s u%0d done", tag, i), dn[i], ms[i] == 1);
            chk($sformatf("%s u%0d err", tag, i), er[i], ms[i] == 2);
            chk($sformatf("%s u%0d cpu_hold", tag, i), hold[i], ms[i] != 1);
            chk($sformatf("%s u%0d in_ready", tag, i), rdy[i], ms[i] == 0);
            chk($sformatf("%s u%0d word_count", tag, i), cnt[i], 16'(mc[i]));
        end
    endtask

    // one clock: check the memory port before the edge, advance the model, check status after it
    task automatic tick(string tag);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic ew;
            logic [15:0] ea, ed;
            ew = ms[i] == 1 ? cpu_mrw : (ms[i] == 0 ? (in_valid && !(CK && in_last)) : 1'b0);
            ea = ms[i] == 1 ? cpu_addr : 16'(ma[i]);
            ed = ms[i] == 1 ? cpu_wdata : in_data;
            chk($sformatf("%s u%0d mem_we", tag, i), we[i], ew);
            if (ew) begin
                chk($sformatf("%s u%0d mem_addr", tag, i), maddr[i], ea);
                chk($sformatf("%s u%0d mem_wdata", tag, i), mwd[i], ed);
                mm[i][ea[11:0]] = ed;
            end
            if (reset) begin
                ms[i] = 0; ma[i] = base[i]; mc[i] = 0; msum[i] = 0;
            end else if (ms[i] == 0 && in_valid) begin
                if (CK && in_last) ms[i] = (msum[i] == in_data) ? 1 : 2;
                else begin
                    mc[i]++;
                    msum[i] += in_data;
                    ms[i] = in_last ? 1 : (ma[i] == 4095 ? 2 : 0);
                    ma[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        chk_status(tag);
    endtask

    task automatic send(string tag, logic [15:0] d, logic l, int gap);
        for (int g = 0; g < gap; g++) tick(tag);
        in_valid = 1; in_data = d; in_last = l;
        tick(tag);
        in_valid = 0; in_last = 0; in_data = 16'($urandom);
    endtask

    task automatic do_reset(string tag);
        in_valid = 0; cpu_mrw = 0; reset = 1;
        tick(tag);
        reset = 0;
    endtask

    task automatic chk_mem(string tag);
        for (int i = 0; i < 2; i++) begin
            int bad = 0;
            for (int a = 0; a < 4096; a++) if (mem[i][a] !== mm[i][a]) bad++;
            chk($sformatf("%s u%0d mem mismatches", tag, i), bad, 0);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem[0][a] = 16'hDEAD; mem[1][a] = 16'hDEAD; mm[0][a] = 16'hDEAD; mm[1][a] = 16'hDEAD;
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_status("reset");
        reset = 0;
        // back-to-back image
        send("b2b", 16'h1111, 0, 0);
        send("b2b", 16'h2222, 0, 0);
        send("b2b", 16'h3333, 1, 0);
        chk("b2b u0 done", dn[0], 1);
        chk("b2b u0 word_count", cnt[0], CK ? 2 : 3);
        chk_mem("b2b");
        // same image with gaps
        do_reset("gap");
        send("gap", 16'h1111, 0, 2);
        send("gap", 16'h2222, 0, 2);
        send("gap", 16'h3333, 1, 2);
        tick("gap");
        chk_mem("gap");
        // overflow on the base-4094 loader
        do_reset("ovf");
        for (int k = 0; k < 3; k++) send("ovf", 16'($urandom), 0, 0);
        chk("ovf u1 err", er[1], 1);
        chk("ovf u1 word_count", cnt[1], 2);
        chk("ovf u1 mem0", mem[1][0], 16'hDEAD);
        chk_mem("ovf");
        // finish u0, then pass-through with in_valid held high
        send("pt", msum[0], 1, 0);
        in_valid = 1; in_data = 16'h5555; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; cpu_mrw = 1;
        tick("pt");
        cpu_mrw = 0; in_valid = 0;
        tick("pt");
        chk("pt u0 mem10", mem[0][16], 16'hBEEF);
        chk_mem("pt");
        // reset mid-load then full reload
        do_reset("rst");
        send("rst", 16'hA001, 0, 0);
        send("rst", 16'hA002, 0, 1);
        do_reset("rst");
        chk("rst u0 word_count", cnt[0], 0);
        chk("rst u0 cpu_hold", hold[0], 1);
        for (int k = 0; k < 3; k++) send("reload", 16'($urandom), 0, 0);
        send("reload", CK ? msum[0] : 16'h0BAD, 1, 0);
        chk("reload u0 done", dn[0], 1);
        chk_mem("reload");
        // checksum directed pair (ordinary data without the feature)
        do_reset("cks");
        send("cks", 16'h0001, 0, 0);
        send("cks", 16'h0002, 0, 0);
        send("cks", 16'h0003, 1, 0);
        do_reset("cks");
        send("cks", 16'h0001, 0, 0);
        send("cks", 16'h0002, 0, 0);
        send("cks", 16'h0004, 1, 0);
        chk_mem("cks");
        // randomized images with random gaps and pass-through traffic
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 20);
            do_reset("rnd");
            for (int k = 0; k < n; k++)
                send("rnd", 16'($urandom), k == n - 1 ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 2));
            if (ms[0] == 0) send("rnd", $urandom_range(0, 1) ? msum[0] : 16'($urandom), 1, 0);
            for (int k = 0; k < 10; k++) begin
                in_valid = 1'($urandom); in_data = 16'($urandom); in_last = 1'($urandom);
                cpu_addr = 16'($urandom_range(0, 4095)); cpu_wdata = 16'($urandom); cpu_mrw = 1'($urandom);
                tick("rnd_pt");
            end
            in_valid = 0; in_last = 0; cpu_mrw = 0;
            chk_mem("rnd");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
